raw12_stream_packer: RTL
========================

RAW12_STREAM_PACKER -- requirements
Module: raw12_stream_packer

Interface
REQ-001 Parameter C_PORT_NUM, 4, samples per clock; SHALL be even and >=2, else elaboration error.
REQ-002 Parameter C_BITS_PER_CPNT, 12, component field width; SHALL be 12 only, else elaboration error.
REQ-003 Parameter C_MAX_CPNTS_PER_PIXEL, 3, component fields per port slot.
REQ-004 Parameter C_FIFO_DEPTH, 512, output FIFO beats; SHALL be a power of two.
REQ-005 VID_CLK  in  1  single clock for all logic.
REQ-006 VID_RSTN  in  1  asynchronous reset, active low.
REQ-007 S_VS, S_HS, S_DE  in  1 each  upstream timing, active high.
REQ-008 S_VID_DATA  in  C_BITS_PER_CPNT*C_MAX_CPNTS_PER_PIXEL*C_PORT_NUM  per port i, RAW sample = bits [36*i +: 12]; other fields ignored.
REQ-009 M_AXIS_TDATA  out  12*C_PORT_NUM  packed RAW12 beat.
REQ-010 M_AXIS_TVALID / M_AXIS_TREADY  out / in  1  AXI-Stream handshake.
REQ-011 M_AXIS_TUSER  out  1  start of frame, first beat of frame only.
REQ-012 M_AXIS_TLAST  out  1  last beat of a line.
REQ-013 LINE_BEATS  out  16  beat count of the most recently completed line.
REQ-014 OVERFLOW  out  1  sticky FIFO-overflow flag; OVF_CLR  in  1  synchronous clear.

Function
REQ-015 Packing per sample pair (p0=port 2k, p1=port 2k+1): byte0=p0[11:4], byte1=p1[11:4], byte2={p1[3:0],p0[3:0]}; pair k occupies TDATA[24k +: 24], byte0 in LSBs.
REQ-016 Edge detect of S_VS and S_DE by one-cycle registered compare; S_HS is not used for framing.
REQ-017 FSM states: SYNC (after reset, wait S_VS rising), FRAME_IDLE (wait S_DE), LINE (S_DE high).
REQ-018 SYNC->FRAME_IDLE on S_VS rising; FRAME_IDLE->LINE on S_DE high; LINE->FRAME_IDLE on S_DE falling; any state->FRAME_IDLE on S_VS rising, aborting an open line.
REQ-019 S_DE beats in SYNC SHALL be discarded (partial frame after reset never emitted).
REQ-020 Stage 1 registers the packed beat on every S_DE cycle; stage 2 holds one beat until its successor or S_DE falling is seen.
REQ-021 Held beat written to FIFO with last=0 when next S_DE beat arrives, last=1 on S_DE falling; write latency = 2 cycles after the following cycle's S_DE value.
REQ-022 SOF flag set on S_VS rising, attached as user=1 to the first beat written after it, then cleared.
REQ-023 Abort via S_VS rising in LINE: held beat written with last=1, user unchanged.
REQ-024 Single-beat line (S_DE high one cycle) SHALL produce one beat with last=1.
REQ-025 FIFO stores {user,last,data}; TVALID = FIFO not empty; pop on TVALID & TREADY; output fall-through, no bubble at full rate.
REQ-026 Write when FIFO full: beat dropped, OVERFLOW set next cycle; simultaneous pop and write at full SHALL succeed without drop.
REQ-027 OVERFLOW cleared by OVF_CLR; set and clear in same cycle -> set wins.
REQ-028 Line beat counter resets on each line start, increments per written-or-dropped beat, saturates at 16'hFFFF, copied to LINE_BEATS when last is issued.

Reset
REQ-029 VID_RSTN low: FSM=SYNC, FIFO empty, TVALID=0, TUSER=0, TLAST=0, TDATA=0, LINE_BEATS=0, OVERFLOW=0, SOF flag=0, edge registers=0.
REQ-030 Reset mid-line discards held and FIFO beats; first output after release is a TUSER=1 beat of the next full frame.

Structure
REQ-031 Shared package holds FSM state enumeration, RAW12 pair width (24) and field offsets.
REQ-032 One sub-module: raw_sync_fifo (parameterized width/depth, full/empty, fall-through read).

Verification
REQ-033 VS pulse, 1 line of 3 beats, TREADY=1, port samples 0xABC,0x123,... -> 3 beats, byte2 of pair0 = 0x3C, TUSER on beat0 only, TLAST on beat2, LINE_BEATS=3.
REQ-034 DE before first VS after reset -> no output; next frame emits TUSER=1 first beat.
REQ-035 TREADY=0 for C_FIFO_DEPTH+5 beats -> exactly 5 beats dropped, OVERFLOW=1 until OVF_CLR, stored beats drain in order.
REQ-036 One-cycle DE line -> single beat with TLAST=1 and TUSER=1.
REQ-037 VS rising while DE high -> held beat emitted with TLAST=1, next beat carries TUSER=1.
REQ-038 Assert VID_RSTN low mid-line with FIFO non-empty -> TVALID=0 immediately (async), no stale beats after release.

Source files
------------

// File: rtl/raw12_stream_packer_pkg.sv
// Shared definitions for the RAW12 stream packer: framing states, pair geometry
// and the per-pair byte packing rule.
package raw12_stream_packer_pkg;

    typedef enum logic [1:0] {
        ST_SYNC       = 2'd0,
        ST_FRAME_IDLE = 2'd1,
        ST_LINE       = 2'd2
    } state_t;

    localparam int RAW_BITS  = 12;
    localparam int PAIR_W    = 24;
    localparam int BYTE0_OFF = 0;
    localparam int BYTE1_OFF = 8;
    localparam int BYTE2_OFF = 16;

    // Two 12-bit samples become three bytes: the MSB bytes of each sample
    // first, then both low nibbles sharing the third byte.
    function automatic logic [PAIR_W-1:0] pack_pair(
        input logic [RAW_BITS-1:0] p0,
        input logic [RAW_BITS-1:0] p1
    );
        logic [PAIR_W-1:0] v;
        v                   = '0;
        v[BYTE0_OFF +: 8]   = p0[11:4];
        v[BYTE1_OFF +: 8]   = p1[11:4];
        v[BYTE2_OFF +: 8]   = {p1[3:0], p0[3:0]};
        return v;
    endfunction

endpackage

// File: rtl/raw12_stream_packer_fifo.sv
// Synchronous FIFO with fall-through read: the head entry is visible on
// o_rd_data whenever the FIFO is not empty, and reads zero when empty.
module raw_sync_fifo #(
    parameter int C_WIDTH = 50,
    parameter int C_DEPTH = 512
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_wr_en,
    input  logic [C_WIDTH-1:0] i_wr_data,
    input  logic               i_rd_en,
    output logic [C_WIDTH-1:0] o_rd_data,
    output logic               o_empty,
    output logic               o_full
);

    localparam int AW = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    if ((C_DEPTH < 2) || ((C_DEPTH & (C_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("raw_sync_fifo: C_DEPTH must be a power of two >= 2");
    end

    logic [C_WIDTH-1:0] r_mem [C_DEPTH];
    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic               w_rd_ok;
    logic               w_wr_ok;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_rd_ok = i_rd_en & ~o_empty;
    // A pop in the same cycle frees the slot, so a write at full still lands.
    assign w_wr_ok = i_wr_en & (~o_full | w_rd_ok);

    always_ff @(posedge i_clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/raw12_stream_packer.sv
// Converts parallel RAW video (VS/HS/DE timing) into an AXI-Stream of packed
// RAW12 beats with start-of-frame on TUSER and end-of-line on TLAST.
module raw12_stream_packer
    import raw12_stream_packer_pkg::*;
#(
    parameter int C_PORT_NUM            = 4,
    parameter int C_BITS_PER_CPNT       = 12,
    parameter int C_MAX_CPNTS_PER_PIXEL = 3,
    parameter int C_FIFO_DEPTH          = 512
) (
    input  logic                                                  VID_CLK,
    input  logic                                                  VID_RSTN,
    input  logic                                                  S_VS,
    input  logic                                                  S_HS,
    input  logic                                                  S_DE,
    input  logic [C_BITS_PER_CPNT*C_MAX_CPNTS_PER_PIXEL*C_PORT_NUM-1:0] S_VID_DATA,
    output logic [12*C_PORT_NUM-1:0]                              M_AXIS_TDATA,
    output logic                                                  M_AXIS_TVALID,
    input  logic                                                  M_AXIS_TREADY,
    output logic                                                  M_AXIS_TUSER,
    output logic                                                  M_AXIS_TLAST,
    output logic [15:0]                                           LINE_BEATS,
    output logic                                                  OVERFLOW,
    input  logic                                                  OVF_CLR
);

    localparam int W_SLOT  = C_BITS_PER_CPNT * C_MAX_CPNTS_PER_PIXEL;
    localparam int W_OUT   = RAW_BITS * C_PORT_NUM;
    localparam int N_PAIRS = C_PORT_NUM / 2;
    localparam int W_BEAT  = W_OUT + 2;

    if ((C_PORT_NUM < 2) || ((C_PORT_NUM % 2) != 0)) begin : g_bad_ports
        $error("raw12_stream_packer: C_PORT_NUM must be even and >= 2");
    end
    if (C_BITS_PER_CPNT != 12) begin : g_bad_bits
        $error("raw12_stream_packer: C_BITS_PER_CPNT must be 12");
    end
    if (C_MAX_CPNTS_PER_PIXEL < 1) begin : g_bad_cpnts
        $error("raw12_stream_packer: C_MAX_CPNTS_PER_PIXEL must be >= 1");
    end

    // Timing edge detection
    logic   r_vs_d;
    logic   r_de_d;
    logic   w_vs_rise;
    logic   w_de_fall;

    assign w_vs_rise = S_VS & ~r_vs_d;
    assign w_de_fall = ~S_DE & r_de_d;

    // Framing FSM
    state_t r_state;
    state_t w_state_next;
    logic   w_capture;
    logic   w_line_start;
    logic   w_line_end;
    logic   w_line_abort;

    always_ff @(posedge VID_CLK or negedge VID_RSTN) begin
        if (!VID_RSTN) begin
            r_state <= ST_SYNC;
            r_vs_d  <= 1'b0;
            r_de_d  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_vs_d  <= S_VS;
            r_de_d  <= S_DE;
        end
    end

    // The sample coinciding with a VS rising edge belongs to neither line:
    // the FSM only re-enters LINE on the following DE cycle.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_line_start = 1'b0;
        w_line_end   = 1'b0;
        w_line_abort = 1'b0;
        if (w_vs_rise) begin
            w_state_next = ST_FRAME_IDLE;
            if (r_state == ST_LINE) begin
                w_line_end   = 1'b1;
                w_line_abort = 1'b1;
            end
        end else begin
            case (r_state)
                ST_SYNC: begin
                    w_state_next = ST_SYNC;
                end
                ST_FRAME_IDLE: begin
                    if (S_DE) begin
                        w_state_next = ST_LINE;
                        w_capture    = 1'b1;
                        w_line_start = 1'b1;
                    end
                end
                ST_LINE: begin
                    w_capture = S_DE;
                    if (w_de_fall) begin
                        w_state_next = ST_FRAME_IDLE;
                        w_line_end   = 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_SYNC;
                end
            endcase
        end
    end

    // Pair packing
    logic [W_OUT-1:0] w_packed;

    for (genvar gi = 0; gi < N_PAIRS; gi++) begin : g_pair
        assign w_packed[PAIR_W*gi +: PAIR_W] = pack_pair(
            S_VID_DATA[W_SLOT*(2*gi)     +: RAW_BITS],
            S_VID_DATA[W_SLOT*(2*gi + 1) +: RAW_BITS]
        );
    end

    // Stage 1 follows the input; stage 2 holds a beat until we know whether
    // it is the last of its line.
    logic             r_s1_valid;
    logic             r_s1_end;
    logic             r_s1_abort;
    logic [W_OUT-1:0] r_s1_data;
    logic             r_s2_valid;
    logic [W_OUT-1:0] r_s2_data;

    always_ff @(posedge VID_CLK or negedge VID_RSTN) begin
        if (!VID_RSTN) begin
            r_s1_valid <= 1'b0;
            r_s1_end   <= 1'b0;
            r_s1_abort <= 1'b0;
            r_s1_data  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
        end else begin
            r_s1_valid <= w_capture;
            r_s1_end   <= w_line_end;
            r_s1_abort <= w_line_abort;
            if (S_DE) begin
                r_s1_data <= w_packed;
            end
            if (r_s1_valid) begin
                r_s2_valid <= 1'b1;
                r_s2_data  <= r_s1_data;
            end else if (r_s1_end) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    // FIFO write side
    logic r_sof;
    logic w_wr_req;
    logic w_wr_last;
    logic w_wr_user;
    logic w_fifo_empty;
    logic w_fifo_full;
    logic w_drop;
    logic [W_BEAT-1:0] w_rd_beat;

    assign w_wr_req  = r_s2_valid & (r_s1_valid | r_s1_end);
    assign w_wr_last = r_s1_end;
    // An aborted line's tail belongs to the old frame, so it neither carries
    // nor consumes the pending start-of-frame mark.
    assign w_wr_user = r_sof & ~r_s1_abort;
    assign w_drop    = w_wr_req & w_fifo_full & ~M_AXIS_TREADY;

    always_ff @(posedge VID_CLK or negedge VID_RSTN) begin
        if (!VID_RSTN) begin
            r_sof <= 1'b0;
        end else if (w_vs_rise) begin
            r_sof <= 1'b1;
        end else if (w_wr_req && !r_s1_abort) begin
            r_sof <= 1'b0;
        end
    end

    raw_sync_fifo #(
        .C_WIDTH (W_BEAT),
        .C_DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (VID_CLK),
        .i_rst_n   (VID_RSTN),
        .i_wr_en   (w_wr_req),
        .i_wr_data ({w_wr_user, w_wr_last, r_s2_data}),
        .i_rd_en   (M_AXIS_TREADY),
        .o_rd_data (w_rd_beat),
        .o_empty   (w_fifo_empty),
        .o_full    (w_fifo_full)
    );

    assign M_AXIS_TVALID = ~w_fifo_empty;
    assign M_AXIS_TUSER  = w_rd_beat[W_BEAT-1];
    assign M_AXIS_TLAST  = w_rd_beat[W_BEAT-2];
    assign M_AXIS_TDATA  = w_rd_beat[W_OUT-1:0];

    // Overflow flag and per-line beat counter
    logic        r_overflow;
    logic [15:0] r_beat_cnt;
    logic [15:0] r_line_beats;
    logic [15:0] w_cnt_inc;

    assign w_cnt_inc = (r_beat_cnt == 16'hFFFF) ? r_beat_cnt : (r_beat_cnt + 16'd1);

    always_ff @(posedge VID_CLK or negedge VID_RSTN) begin
        if (!VID_RSTN) begin
            r_overflow   <= 1'b0;
            r_beat_cnt   <= '0;
            r_line_beats <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (OVF_CLR) begin
                r_overflow <= 1'b0;
            end
            // A line start can only coincide with the previous line's last
            // write, which clears the counter anyway.
            if (w_wr_req) begin
                if (w_wr_last) begin
                    r_line_beats <= w_cnt_inc;
                    r_beat_cnt   <= '0;
                end else begin
                    r_beat_cnt <= w_cnt_inc;
                end
            end else if (w_line_start) begin
                r_beat_cnt <= '0;
            end
        end
    end

    assign LINE_BEATS = r_line_beats;
    assign OVERFLOW   = r_overflow;

    // HS and the non-RAW component fields carry nothing used here.
    logic w_unused;
    assign w_unused = ^{S_HS, S_VID_DATA};

endmodule
